// File: rtl/mem_stream_loader.sv
// rtl/mem_stream_loader.sv - boot loader: length-prefixed byte stream packed into 32-bit RAM writes
module mem_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_BYTES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [23:0] r_len;        // low three header bytes; the fourth arrives on the decision cycle
    logic [1:0]  r_hcnt;
    logic [31:0] r_wlen;       // bytes actually written to RAM
    logic [31:0] r_drem;       // bytes still to be discarded after the RAM is full
    logic [31:0] r_cnt;        // payload bytes accepted so far
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb_acc;   // lanes filled so far; kept off the bus until the word is issued
    logic [3:0]  r_mem_wstrb;
    logic        r_mem_valid;
    logic        r_busy;
    logic        r_err;

    logic        w_in_fire;
    logic        w_mem_fire;
    logic        w_word_end;
    logic [31:0] w_hdr_len;
    logic [1:0]  w_lane;

    assign in_ready   = resetn && (r_state == S_HDR || r_state == S_DATA || r_state == S_DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_mem_fire = r_mem_valid && mem_ready;
    assign w_hdr_len  = {in_data, r_len};
    assign w_lane     = r_cnt[1:0];
    assign w_word_end = (w_lane == 2'd3) || (r_cnt + 32'd1 == r_wlen);

    assign mem_valid  = r_mem_valid;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = r_busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_in_fire && r_hcnt == 2'd3) begin
                    w_next = (w_hdr_len == 32'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_in_fire && w_word_end) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_mem_fire) begin
                    if (r_cnt < r_wlen) begin
                        w_next = S_DATA;
                    end else if (r_drem != 32'd0) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (w_in_fire && r_drem == 32'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (restart) begin
                    w_next = S_HDR;
                end
            end
            default: w_next = S_HDR;
        endcase
    end

    // Header capture, word packing, memory request and status flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_len       <= 24'd0;
            r_hcnt      <= 2'd0;
            r_wlen      <= 32'd0;
            r_drem      <= 32'd0;
            r_cnt       <= 32'd0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= 32'd0;
            r_strb_acc  <= 4'd0;
            r_mem_wstrb <= 4'd0;
            r_mem_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_in_fire) begin
                        r_busy <= 1'b1;
                        r_hcnt <= r_hcnt + 2'd1;
                        case (r_hcnt)
                            2'd0:    r_len[7:0]   <= in_data;
                            2'd1:    r_len[15:8]  <= in_data;
                            2'd2:    r_len[23:16] <= in_data;
                            default: begin
                                r_cnt      <= 32'd0;
                                r_addr     <= BASE_ADDR;
                                r_wdata    <= 32'd0;
                                r_strb_acc <= 4'd0;
                                if (w_hdr_len > MAX_LEN) begin
                                    r_err  <= 1'b1;
                                    r_wlen <= MAX_LEN;
                                    r_drem <= w_hdr_len - MAX_LEN;
                                end else begin
                                    r_wlen <= w_hdr_len;
                                    r_drem <= 32'd0;
                                end
                            end
                        endcase
                    end
                end
                S_DATA: begin
                    if (w_in_fire) begin
                        r_wdata[{w_lane, 3'b000} +: 8] <= in_data;
                        r_cnt <= r_cnt + 32'd1;
                        if (w_word_end) begin
                            r_mem_valid <= 1'b1;
                            r_mem_wstrb <= r_strb_acc | (4'd1 << w_lane);
                            r_strb_acc  <= 4'd0;
                        end else begin
                            r_strb_acc[w_lane] <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_mem_fire) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'd0;
                        r_wdata     <= 32'd0;
                        r_addr      <= r_addr + 32'd4;
                    end
                end
                S_DRAIN: begin
                    if (w_in_fire) begin
                        r_drem <= r_drem - 32'd1;
                    end
                end
                S_DONE: begin
                    if (restart) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (w_next == S_DONE && r_state != S_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stream_loader.sv
// tb/tb_mem_stream_loader.sv - self-checking bench for mem_stream_loader
`timescale 1ns/1ps
module tb_mem_stream_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_valid_cycles = 0;
    int stall    = 0;
    int ram_wait = 0;
    logic        ram_ready;
    logic [31:0] last_addr;

    logic [31:0] ram     [256] = '{default: 32'd0};
    logic [31:0] exp_ram [256] = '{default: 32'd0};
    logic [67:0] exp_q [$];
    logic [7:0]  pay [$];

    logic        p_valid = 1'b0;
    logic        p_fire  = 1'b0;
    logic [67:0] p_bus   = 68'd0;

    assign mem_ready = ram_ready;

    mem_stream_loader #(.BASE_ADDR(BASE), .MAX_BYTES(1024)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM model: ready is registered from valid, optionally delayed by 'stall' cycles
    always @(posedge clk) begin
        if (!resetn) begin
            ram_ready <= 1'b0;
            ram_wait  <= 0;
        end else if (mem_valid && !ram_ready) begin
            if (ram_wait >= stall) begin
                ram_ready <= 1'b1;
                ram_wait  <= 0;
            end else begin
                ram_wait <= ram_wait + 1;
            end
        end else begin
            ram_ready <= 1'b0;
        end
    end

    // Bus monitor: protocol checks, RAM update and scoreboard pop on every completion
    always @(negedge clk) begin
        logic [67:0] e;
        if (resetn) begin
            if (!mem_valid) check("wstrb_idle", {64'd0, mem_wstrb}, 68'd0);
            if (mem_valid) begin
                n_valid_cycles++;
                check("in_ready_in_write", {67'd0, in_ready}, 68'd0);
            end
            if (mem_valid && p_valid && !p_fire)
                check("bus_stable", {mem_addr, mem_wdata, mem_wstrb}, p_bus);
            if (mem_valid && mem_ready) begin
                n_writes++;
                last_addr = mem_addr;
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {mem_addr, mem_wdata, mem_wstrb}, 68'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {mem_addr, mem_wdata, mem_wstrb}, e);
                end
            end
        end
        p_valid <= mem_valid && resetn;
        p_fire  <= mem_valid && mem_ready;
        p_bus   <= {mem_addr, mem_wdata, mem_wstrb};
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept_timeout", {67'd0, t >= 200}, 68'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] len);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", {67'd0, t >= 5000}, 68'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    // Sends header and 'pay'; expected writes are pushed as the bytes that complete each word go out
    task automatic load(input logic [31:0] len);
        int wlen;
        logic [31:0] w;
        logic [3:0]  s;
        wlen = (len > 32'd1024) ? 1024 : int'(len);
        w = 32'd0;
        s = 4'd0;
        send_hdr(len);
        for (int i = 0; i < pay.size(); i++) begin
            if (i < wlen) begin
                w[8*(i%4) +: 8] = pay[i];
                s[i%4] = 1'b1;
                exp_ram[BASE[9:2] + i/4][8*(i%4) +: 8] = pay[i];
                if ((i % 4) == 3 || i == wlen - 1) begin
                    exp_q.push_back({BASE + 32'(4*(i/4)), w, s});
                    w = 32'd0;
                    s = 4'd0;
                end
            end
            send_byte(pay[i]);
        end
        wait_done();
        check("done", {67'd0, done}, 68'd1);
        check("busy_after_done", {67'd0, busy}, 68'd0);
        check("err", {67'd0, err}, {67'd0, len > 32'd1024});
        check("scoreboard_empty", 68'(exp_q.size()), 68'd0);
    endtask

    task automatic check_ram(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) check("ram_word", {36'd0, ram[i]}, {36'd0, exp_ram[i]});
    endtask

    initial begin
        int w0;
        int v0;
        resetn   = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        check("rst_mem_valid", {67'd0, mem_valid}, 68'd0);
        check("rst_wstrb", {64'd0, mem_wstrb}, 68'd0);
        check("rst_addr", {36'd0, mem_addr}, {36'd0, BASE});
        check("rst_wdata", {36'd0, mem_wdata}, 68'd0);
        check("rst_flags", {65'd0, busy, done, err}, 68'd0);
        check("rst_in_ready", {67'd0, in_ready}, 68'd1);

        // Two full words
        w0 = n_writes;
        pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(32'd8);
        check("t1_writes", 68'(n_writes - w0), 68'd2);
        check_ram(0, 1);
        check("t1_word0", {36'd0, ram[0]}, {36'd0, 32'h04030201});

        // Partial final word keeps the untouched lanes
        pulse_restart();
        w0 = n_writes;
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load(32'd5);
        check("t2_writes", 68'(n_writes - w0), 68'd2);
        check_ram(0, 1);
        check("t2_word1", {36'd0, ram[1]}, {36'd0, 32'h080706EE});

        // Zero length: straight to DONE, no bus activity
        pulse_restart();
        v0 = n_valid_cycles;
        w0 = n_writes;
        send_hdr(32'd0);
        check("t3_done_next_cycle", {67'd0, done}, 68'd1);
        check("t3_no_valid", 68'(n_valid_cycles - v0), 68'd0);
        check("t3_no_writes", 68'(n_writes - w0), 68'd0);

        // RAM stalls for several cycles
        pulse_restart();
        stall = 5;
        w0 = n_writes;
        v0 = n_valid_cycles;
        pay = {8'h11, 8'h22, 8'h33, 8'h44};
        load(32'd4);
        check("t4_writes", 68'(n_writes - w0), 68'd1);
        check("t4_valid_cycles", 68'(n_valid_cycles - v0), 68'd7);
        check_ram(0, 0);
        stall = 0;

        // Oversize length: capped writes, drained tail, sticky err, then restart
        pulse_restart();
        w0 = n_writes;
        pay.delete();
        for (int i = 0; i < 1030; i++) pay.push_back(8'(i * 7 + 3));
        load(32'd1030);
        check("t5_writes", 68'(n_writes - w0), 68'd256);
        check("t5_last_addr", {36'd0, last_addr}, {36'd0, 32'h0000_03FC});
        check_ram(254, 255);
        pulse_restart();
        check("t5_restart_done", {67'd0, done}, 68'd0);
        check("t5_restart_err", {67'd0, err}, 68'd0);
        w0 = n_writes;
        pay = {8'hC0, 8'hDE, 8'hF0, 8'h0D};
        load(32'd4);
        check("t5_reload_writes", 68'(n_writes - w0), 68'd1);
        check_ram(0, 0);

        // Reset while a write is outstanding
        pulse_restart();
        stall = 5;
        send_hdr(32'd8);
        for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i));
        check("t6_in_write", {67'd0, mem_valid}, 68'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("t6_in_ready_in_reset", {67'd0, in_ready}, 68'd0);
        @(negedge clk);
        resetn = 1'b1;
        check("t6_mem_valid", {67'd0, mem_valid}, 68'd0);
        check("t6_wstrb", {64'd0, mem_wstrb}, 68'd0);
        check("t6_flags", {65'd0, busy, done, err}, 68'd0);
        check("t6_addr", {36'd0, mem_addr}, {36'd0, BASE});
        @(negedge clk);
        check("t6_hdr_ready", {67'd0, in_ready}, 68'd1);
        stall = 0;
        w0 = n_writes;
        pay = {8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
        load(32'd5);
        check("t6_writes", 68'(n_writes - w0), 68'd2);
        check_ram(0, 1);
        check("t6_word0", {36'd0, ram[0]}, {36'd0, 32'h94939291});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
